// File: rtl/rpc_pkg.sv
// Shared encodings for the next-address generator: flow commands and FSM states.
package rpc_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SEQ   = 3'd0,
    OP_RJMP  = 3'd1,
    OP_JMP   = 3'd2,
    OP_RCALL = 3'd3,
    OP_CALL  = 3'd4,
    OP_RET   = 3'd5,
    OP_HOLD  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/rpc_stack.sv
// Return-address LIFO with registered contents/count and a combinational top-of-stack read.
module rpc_stack #(
  parameter int unsigned size_data   = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [size_data-1:0]               din,
  output logic [size_data-1:0]               top_c,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   cnt,
  output logic                               full_c,
  output logic                               empty_c
);

  localparam int unsigned AW    = size_data;
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0]    mem_q [STACK_DEPTH];
  logic [AW-1:0]    mem_d [STACK_DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign full_c  = (cnt_q == CNT_W'(STACK_DEPTH));
  assign empty_c = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign top_c   = empty_c ? '0 : mem_q[IDX_W'(cnt_q - CNT_W'(1))];

  // Push beats pop; requests that would over/underflow are dropped here.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full_c) begin
      mem_d[IDX_W'(cnt_q)] = din;
      cnt_d                = cnt_q + CNT_W'(1);
    end else if (pop && !empty_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rpc_next.sv
// Next-PC generator: boot/run/fault FSM, address adder, next-address mux, return stack.
// Optional RPC_IRQ_VECTOR_EN adds an irq input that vectors to IRQ_VEC and pushes the current PC.
module rpc_next
  import rpc_pkg::*;
#(
  parameter int unsigned size_data   = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_VEC   = 0,
  parameter int unsigned IRQ_VEC     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
`ifdef RPC_IRQ_VECTOR_EN
  input  logic                             irq,
`endif
  input  logic [OP_W-1:0]                  op,
  input  logic [size_data-1:0]             offset,
  input  logic [size_data-1:0]             target,
  input  logic [size_data-1:0]             pc_Daddr,
  output logic [size_data-1:0]             pc_Newaddr,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stk_cnt,
  output logic                             stk_full,
  output logic                             stk_empty,
  output logic                             fault
);

  localparam int unsigned AW = size_data;

  state_e        state_q, state_d;
  logic          fault_q, fault_d;
  logic          push_c, pop_c;
  logic [AW-1:0] push_data_c;
  logic [AW-1:0] top_c;
  logic [AW-1:0] p1_c;
  logic [AW-1:0] rel_c;
  logic          full_c, empty_c;
  logic          irq_c;

`ifdef RPC_IRQ_VECTOR_EN
  assign irq_c = irq;
`else
  assign irq_c = 1'b0;
`endif

  assign p1_c  = pc_Daddr + AW'(1);
  assign rel_c = p1_c + offset;

  rpc_stack #(
    .size_data   (size_data),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst),
    .push    (push_c),
    .pop     (pop_c),
    .din     (push_data_c),
    .top_c   (top_c),
    .cnt     (stk_cnt),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Next-state and next-address decode; the default hold covers stall and fault.
  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    pc_Newaddr  = pc_Daddr;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    push_data_c = p1_c;
    case (state_q)
      S_BOOT: begin
        pc_Newaddr = AW'(RESET_VEC);
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (en) begin
          if (irq_c) begin
            if (full_c) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end else begin
              push_c      = 1'b1;
              push_data_c = pc_Daddr;
              pc_Newaddr  = AW'(IRQ_VEC);
            end
          end else begin
            case (op)
              OP_RJMP: pc_Newaddr = rel_c;
              OP_JMP:  pc_Newaddr = target;
              OP_RCALL, OP_CALL: begin
                if (full_c) begin
                  fault_d = 1'b1;
                  state_d = S_FAULT;
                end else begin
                  push_c     = 1'b1;
                  pc_Newaddr = (op == OP_CALL) ? target : rel_c;
                end
              end
              OP_RET: begin
                if (empty_c) begin
                  fault_d = 1'b1;
                  state_d = S_FAULT;
                end else begin
                  pop_c      = 1'b1;
                  pc_Newaddr = top_c;
                end
              end
              OP_HOLD: pc_Newaddr = pc_Daddr;
              default: pc_Newaddr = p1_c;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign fault     = fault_q;
  assign stk_full  = full_c;
  assign stk_empty = empty_c;

endmodule
